// File: rtl/diff_commit_queue_pkg.sv
// Shared types and widths for the difftest commit queue.
// Entries are stored at the widest supported XLEN (64). Narrower
// configurations zero-extend pc/wdata on write and truncate on read.
package diff_pkg;

   localparam int DIFF_INDEX_W  = 8;
   localparam int DIFF_INSTR_W  = 32;
   localparam int DIFF_WDEST_W  = 8;
   localparam int DIFF_XLEN_MAX = 64;

   typedef struct packed {
      logic [DIFF_INDEX_W-1:0]  index;
      logic [DIFF_XLEN_MAX-1:0] pc;
      logic [DIFF_INSTR_W-1:0]  instr;
      logic                     skip;
      logic                     wen;
      logic [DIFF_WDEST_W-1:0]  wdest;
      logic [DIFF_XLEN_MAX-1:0] wdata;
   } diff_commit_t;

endpackage

// File: rtl/diff_commit_queue_if.sv
// Writeback-side commit group and bridge-side single-commit port.
//
// Handshake:
// - in side: a group is absorbed on a rising clock edge when in_ready=1.
//   Lanes whose in_valid bit is 0 are ignored. If in_valid != 0 while
//   in_ready=0, the whole group is dropped. No partial acceptance.
// - out side: strict valid/ready. The head transfers on a rising edge when
//   out_valid && out_ready. While out_valid && !out_ready the out_* fields
//   hold steady. out_valid never depends on out_ready.
interface diff_commit_queue_if #(
   parameter int COMMIT_WIDTH = 4,
   parameter int XLEN         = 64
);
   import diff_pkg::*;

   logic [COMMIT_WIDTH-1:0]              in_valid;
   logic [COMMIT_WIDTH*XLEN-1:0]         in_pc;
   logic [COMMIT_WIDTH*DIFF_INSTR_W-1:0] in_instr;
   logic [COMMIT_WIDTH-1:0]              in_skip;
   logic [COMMIT_WIDTH-1:0]              in_wen;
   logic [COMMIT_WIDTH*DIFF_WDEST_W-1:0] in_wdest;
   logic [COMMIT_WIDTH*XLEN-1:0]         in_wdata;
   logic                                 in_ready;

   logic                                 out_valid;
   logic                                 out_ready;
   logic [DIFF_INDEX_W-1:0]              out_index;
   logic [XLEN-1:0]                      out_pc;
   logic [DIFF_INSTR_W-1:0]              out_instr;
   logic                                 out_skip;
   logic                                 out_wen;
   logic [DIFF_WDEST_W-1:0]              out_wdest;
   logic [XLEN-1:0]                      out_wdata;

   modport master (
      output in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata, out_ready,
      input  in_ready, out_valid, out_index, out_pc, out_instr, out_skip, out_wen,
             out_wdest, out_wdata
   );

   modport slave (
      input  in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata, out_ready,
      output in_ready, out_valid, out_index, out_pc, out_instr, out_skip, out_wen,
             out_wdest, out_wdata
   );

endinterface

// File: rtl/diff_lane_compactor.sv
// Combinational lane compactor: each lane's rank is the number of valid
// lanes below it (exclusive prefix popcount). That rank is both the write
// offset from wr_ptr and the index-stamp offset. nvalid is the total count.
module diff_lane_compactor #(
   parameter int COMMIT_WIDTH = 4
) (
   input  logic [COMMIT_WIDTH-1:0]                           valid,
   output logic [COMMIT_WIDTH-1:0][$clog2(COMMIT_WIDTH+1)-1:0] rank,
   output logic [$clog2(COMMIT_WIDTH+1)-1:0]                 nvalid
);

   localparam int RANK_W = $clog2(COMMIT_WIDTH+1);

   logic [RANK_W-1:0] running;

   // Ripple prefix count across lanes in ascending order.
   always_comb begin
      running = '0;
      rank    = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         rank[i] = running;
         running = running + RANK_W'(valid[i]);
      end
      nvalid = running;
   end

endmodule

// File: rtl/diff_commit_queue.sv
// Multi-lane difftest commit queue. Up to COMMIT_WIDTH retired instructions
// per cycle are compacted in lane order into a circular buffer. The queue
// drains one commit per cycle, first-word fall-through, and stamps each
// commit with a wrapping 8-bit index.
// Optional build macro: DIFF_QUEUE_STAT_EN adds the stat_hwm, stat_commits
// and stat_stall counters.
module diff_commit_queue
   import diff_pkg::*;
#(
   parameter int COMMIT_WIDTH = 4,
   parameter int DEPTH        = 16,
   parameter int XLEN         = 64
) (
   input  logic                       clock,
   input  logic                       reset,
   diff_commit_queue_if.slave         bus,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
`ifdef DIFF_QUEUE_STAT_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] stat_hwm,
   output logic [63:0]                stat_commits,
   output logic [31:0]                stat_stall
`endif
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam int RANK_W = $clog2(COMMIT_WIDTH+1);
   // A full group fits only while count <= DEPTH - COMMIT_WIDTH.
   localparam logic [CNT_W-1:0] FILL_LIMIT = CNT_W'(DEPTH - COMMIT_WIDTH);

   diff_commit_t                      mem [DEPTH];
   diff_commit_t                      head;
   logic [PTR_W-1:0]                  wr_ptr;
   logic [PTR_W-1:0]                  rd_ptr;
   logic [DIFF_INDEX_W-1:0]           next_index;
   logic [COMMIT_WIDTH-1:0][RANK_W-1:0] rank;
   logic [RANK_W-1:0]                 nvalid;
   logic                              accept;
   logic                              drop;
   logic                              deq;
   logic [CNT_W-1:0]                  count_next;

   diff_lane_compactor #(
      .COMMIT_WIDTH (COMMIT_WIDTH)
   ) u_compactor (
      .valid  (bus.in_valid),
      .rank   (rank),
      .nvalid (nvalid)
   );

   // in_ready uses only the registered count. A same-cycle dequeue does not
   // make room, which keeps the ready path short.
   assign bus.in_ready  = (count <= FILL_LIMIT);
   assign accept        = bus.in_ready && (bus.in_valid != '0);
   assign drop          = !bus.in_ready && (bus.in_valid != '0);
   assign bus.out_valid = (count != '0);
   assign deq           = bus.out_valid && bus.out_ready;

   // Occupancy update: enqueue and dequeue can both happen in one cycle.
   always_comb begin
      count_next = count;
      if (accept) count_next = count_next + CNT_W'(nvalid);
      if (deq)    count_next = count_next - CNT_W'(1);
   end

   // Storage write: scatter the valid lanes to consecutive slots and stamp each index.
   always_ff @(posedge clock) begin
      if (!reset && accept) begin
         for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (bus.in_valid[i]) begin
               mem[wr_ptr + PTR_W'(rank[i])] <= '{
                  index: next_index + DIFF_INDEX_W'(rank[i]),
                  pc:    DIFF_XLEN_MAX'(bus.in_pc[i*XLEN +: XLEN]),
                  instr: bus.in_instr[i*DIFF_INSTR_W +: DIFF_INSTR_W],
                  skip:  bus.in_skip[i],
                  wen:   bus.in_wen[i],
                  wdest: bus.in_wdest[i*DIFF_WDEST_W +: DIFF_WDEST_W],
                  wdata: DIFF_XLEN_MAX'(bus.in_wdata[i*XLEN +: XLEN])
               };
            end
         end
      end
   end

   // Pointers, occupancy, index counter and sticky overflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         next_index <= '0;
         overflow   <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr     <= wr_ptr + PTR_W'(nvalid);
            next_index <= next_index + DIFF_INDEX_W'(nvalid);
         end
         if (deq)  rd_ptr   <= rd_ptr + PTR_W'(1);
         if (drop) overflow <= 1'b1;
         count <= count_next;
      end
   end

   // Head presentation is first-word fall-through. Output fields are forced
   // to zero while empty so that stale storage never reaches the bridge.
   assign head = mem[rd_ptr];

   // Drive the output fields from the head entry, or zero while empty.
   always_comb begin
      bus.out_index = '0;
      bus.out_pc    = '0;
      bus.out_instr = '0;
      bus.out_skip  = 1'b0;
      bus.out_wen   = 1'b0;
      bus.out_wdest = '0;
      bus.out_wdata = '0;
      if (bus.out_valid) begin
         bus.out_index = head.index;
         bus.out_pc    = head.pc[XLEN-1:0];
         bus.out_instr = head.instr;
         bus.out_skip  = head.skip;
         bus.out_wen   = head.wen;
         bus.out_wdest = head.wdest;
         bus.out_wdata = head.wdata[XLEN-1:0];
      end
   end

`ifdef DIFF_QUEUE_STAT_EN
   // Statistics: high-water mark plus saturating commit and stall counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_hwm     <= '0;
         stat_commits <= '0;
         stat_stall   <= '0;
      end else begin
         if (count_next > stat_hwm) stat_hwm <= count_next;
         if (deq && (stat_commits != '1)) stat_commits <= stat_commits + 64'd1;
         if (bus.out_valid && !bus.out_ready && (stat_stall != '1))
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_diff_commit_queue.sv
// Directed bench for diff_commit_queue. Each commit has its expected fields
// pushed into exp_q when the commit is driven. A negedge monitor pops and
// compares every head transfer, and occupancy and flags are checked inline.
`timescale 1ns/1ps
module tb_diff_commit_queue;
   import diff_pkg::*;

   localparam int W     = 4;
   localparam int DEPTH = 16;
   localparam int XLEN  = 64;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int EXP_W = 8 + 64 + 32 + 1 + 1 + 8 + 64;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [CNT_W-1:0] count;
   logic             overflow;
`ifdef DIFF_QUEUE_STAT_EN
   logic [CNT_W-1:0] stat_hwm;
   logic [63:0]      stat_commits;
   logic [31:0]      stat_stall;
`endif

   diff_commit_queue_if #(.COMMIT_WIDTH(W), .XLEN(XLEN)) dif ();

   diff_commit_queue #(.COMMIT_WIDTH(W), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (dif),
      .count        (count),
      .overflow     (overflow)
`ifdef DIFF_QUEUE_STAT_EN
      ,
      .stat_hwm     (stat_hwm),
      .stat_commits (stat_commits),
      .stat_stall   (stat_stall)
`endif
   );

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   logic [7:0]       exp_idx;
   int               total  = 0;
   int               passed = 0;

   // Derived lane fields: every field except pc is a fixed function of pc.
   function automatic logic [31:0] instr_of(input logic [63:0] p);
      return p[31:0] ^ 32'h0000_0013;
   endfunction
   function automatic logic [63:0] wdata_of(input logic [63:0] p);
      return {p[31:0], ~p[31:0]};
   endfunction
   function automatic logic [7:0] wdest_of(input logic [63:0] p);
      return p[9:2];
   endfunction

   function automatic logic [EXP_W-1:0] pack(input logic [7:0] idx, input logic [63:0] p);
      return {idx, p, instr_of(p), p[3], p[2], wdest_of(p), wdata_of(p)};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s got=%0h required=%0h", name, got, want);
   endtask

   // ---------------- driver tasks ----------------
   // Drive one group for one cycle. The caller states whether the DUT is
   // expected to accept it. Lane i carries pc = base + 4*i.
   task automatic drive_group(input logic [3:0] v, input logic [63:0] base, input bit expect_acc);
      logic [63:0] p;
      for (int i = 0; i < W; i++) begin
         p = base + 64'(4 * i);
         dif.in_pc[i*XLEN +: XLEN]  = p;
         dif.in_instr[i*32 +: 32]   = instr_of(p);
         dif.in_skip[i]             = p[3];
         dif.in_wen[i]              = p[2];
         dif.in_wdest[i*8 +: 8]     = wdest_of(p);
         dif.in_wdata[i*XLEN +: XLEN] = wdata_of(p);
         if (v[i] && expect_acc) begin
            exp_q.push_back(pack(exp_idx, p));
            exp_idx = exp_idx + 8'd1;
         end
      end
      dif.in_valid = v;
      @(posedge clock); #1;
      dif.in_valid = '0;
   endtask

   task automatic do_reset(input int cycles, input logic [3:0] v);
      reset        = 1'b1;
      dif.in_valid = v;
      exp_q.delete();
      exp_idx      = 8'd0;
      repeat (cycles) @(posedge clock);
      #1;
      reset        = 1'b0;
      dif.in_valid = '0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((count != '0 || exp_q.size() != 0) && n < 400) begin
         @(posedge clock); #1;
         n++;
      end
      check({name, "_drain_count"}, 64'(count), 64'd0);
      check({name, "_drain_queue"}, 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- monitor ----------------
   logic [EXP_W-1:0] got_e;
   logic [EXP_W-1:0] exp_e;
   always @(negedge clock) begin
      if (!reset && dif.out_valid && dif.out_ready) begin
         got_e = {dif.out_index, dif.out_pc, dif.out_instr, dif.out_skip, dif.out_wen,
                  dif.out_wdest, dif.out_wdata};
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL out_unexpected got idx=%0d pc=%0h required=no transfer",
                     dif.out_index, dif.out_pc);
         end else begin
            exp_e = exp_q.pop_front();
            if (got_e === exp_e) passed++;
            else $display("FAIL out_entry got idx=%0d pc=%0h entry=%0h required idx=%0d pc=%0h entry=%0h",
                          dif.out_index, dif.out_pc, got_e, exp_e[EXP_W-1 -: 8],
                          exp_e[EXP_W-9 -: 64], exp_e);
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      reset         = 1'b1;
      dif.in_valid  = '0;
      dif.in_pc     = '0;
      dif.in_instr  = '0;
      dif.in_skip   = '0;
      dif.in_wen    = '0;
      dif.in_wdest  = '0;
      dif.in_wdata  = '0;
      dif.out_ready = 1'b0;
      exp_idx       = 8'd0;

      // Reset held two cycles with all lanes valid: nothing may be enqueued.
      do_reset(2, 4'hF);
      check("rst_count",     64'(count),         64'd0);
      check("rst_out_valid", 64'(dif.out_valid), 64'd0);
      check("rst_in_ready",  64'(dif.in_ready),  64'd1);
      check("rst_overflow",  64'(overflow),      64'd0);
      check("rst_out_pc",    dif.out_pc,         64'd0);
      @(posedge clock); #1;
      check("rst_count_idle", 64'(count), 64'd0);

      // Compaction: 1011 yields pcs ...00, ...04, ...0C. Then 1010 yields two more.
      dif.out_ready = 1'b1;
      drive_group(4'b1011, 64'h8000_0000, 1'b1);
      check("compact_count_a", 64'(count), 64'd3);
      drive_group(4'b1010, 64'h8000_0100, 1'b1);
      check("compact_count_b", 64'(count), 64'd4);
      wait_drain("compact");

      // Fill with full groups and no drain, then overflow on the fifth group.
      dif.out_ready = 1'b0;
      for (int g = 0; g < 4; g++) begin
         drive_group(4'hF, 64'h1000 + 64'(16 * g), 1'b1);
         check("fill_count", 64'(count), 64'(4 * (g + 1)));
         if (g == 2) check("fill_ready_at_12", 64'(dif.in_ready), 64'd1);
      end
      check("fill_ready_at_16", 64'(dif.in_ready), 64'd0);
      check("fill_no_ovf_yet",  64'(overflow),     64'd0);
      drive_group(4'hF, 64'h1040, 1'b0);
      check("fill_overflow",    64'(overflow), 64'd1);
      check("fill_count_held",  64'(count),    64'd16);
      repeat (3) @(posedge clock);
      #1;
      check("fill_overflow_sticky", 64'(overflow), 64'd1);
      dif.out_ready = 1'b1;
      wait_drain("fill");
      check("fill_overflow_after_drain", 64'(overflow), 64'd1);

      // Steady state: one in, one out per cycle holds occupancy at 8.
      do_reset(1, 4'h0);
      check("steady_ovf_cleared", 64'(overflow), 64'd0);
      dif.out_ready = 1'b0;
      drive_group(4'hF, 64'h2000, 1'b1);
      drive_group(4'hF, 64'h2010, 1'b1);
      check("steady_count_init", 64'(count), 64'd8);
      dif.out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         drive_group(4'b0001, 64'h3000 + 64'(16 * k), 1'b1);
         check("steady_count", 64'(count), 64'd8);
      end
      check("steady_no_overflow", 64'(overflow), 64'd0);
      wait_drain("steady");

      // Index wrap: 258 single-lane commits take the index through 255 and back to 0, 1.
      do_reset(1, 4'h0);
      dif.out_ready = 1'b1;
      for (int k = 0; k < 258; k++) begin
         drive_group(4'(1 << (k % 4)), 64'h4000 + 64'(16 * k), 1'b1);
      end
      wait_drain("wrap");
      check("wrap_overflow", 64'(overflow), 64'd0);

      // Mid-operation reset discards 10 queued entries and restarts the index at 0.
      dif.out_ready = 1'b0;
      drive_group(4'hF,    64'h5000, 1'b1);
      drive_group(4'hF,    64'h5010, 1'b1);
      drive_group(4'b0011, 64'h5020, 1'b1);
      check("midrst_count_before", 64'(count), 64'd10);
      do_reset(1, 4'hF);
      check("midrst_count",     64'(count),         64'd0);
      check("midrst_out_valid", 64'(dif.out_valid), 64'd0);
      check("midrst_out_index", 64'(dif.out_index), 64'd0);
      dif.out_ready = 1'b1;
      drive_group(4'b0100, 64'h6000, 1'b1);
      wait_drain("midrst");

      repeat (2) @(posedge clock);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/diff_commit_queue.md
Name: diff_commit_queue

Overview:
- Parametrised successor to the single-lane difftest commit bridge.
- Accepts up to COMMIT_WIDTH retired instructions per cycle from a superscalar writeback stage and compacts the valid lanes in lane order.
- Buffers them in a circular queue.
- Drains one commit per cycle over a valid/ready port to the DPI-C difftest commit bridge, stamping a wrapping commit index.

Parameters:
- COMMIT_WIDTH, 4, commit lanes per cycle (1..8).
- DEPTH, 16, queue entries; power of two, >= 2*COMMIT_WIDTH.
- XLEN, 64, width of pc/wdata.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  COMMIT_WIDTH  per-lane commit valid; lane i = bit i
- in_pc  in  COMMIT_WIDTH*XLEN  lane i pc at [i*XLEN +: XLEN]
- in_instr  in  COMMIT_WIDTH*32  lane instruction words
- in_skip  in  COMMIT_WIDTH  lane skip-compare flag
- in_wen  in  COMMIT_WIDTH  lane GPR write enable
- in_wdest  in  COMMIT_WIDTH*8  lane destination register
- in_wdata  in  COMMIT_WIDTH*XLEN  lane write data
- in_ready  out  1  queue can absorb a full COMMIT_WIDTH group this cycle
- out_valid  out  1  head entry valid
- out_ready  in  1  bridge consumes head
- out_index  out  8  commit index of head entry
- out_pc  out  XLEN  head pc
- out_instr  out  32  head instruction
- out_skip  out  1  head skip flag
- out_wen  out  1  head write enable
- out_wdest  out  8  head destination
- out_wdata  out  XLEN  head write data
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky error: commits dropped

Behaviour:
- Reset (synchronous, active-high; clock rising edge): wr_ptr=0, rd_ptr=0, count=0, next_index=0, overflow=0.
  - Resulting outputs: out_valid=0, in_ready=1.
  - out_* data fields reset to 0 (storage is don't-care).
- Reset asserted mid-operation discards all queued entries. The same-cycle in_valid is ignored.
- in_ready = (DEPTH - count) >= COMMIT_WIDTH.
  - Computed from registered count only; same-cycle dequeue is not credited.
  - All-or-nothing acceptance: no partial groups.
- Enqueue when in_ready=1:
  - nvalid = popcount(in_valid).
  - Valid lanes are written in ascending lane order to wr_ptr, wr_ptr+1, ... (mod DEPTH); invalid lanes are skipped (compaction).
  - wr_ptr += nvalid.
  - Any valid pattern is legal, e.g. 4'b1010.
- Stamp: each enqueued entry is stamped with next_index + k, where k is its rank among the valid lanes (mod 256). next_index += nvalid.
- Drop: in_valid != 0 while in_ready=0:
  - Whole group dropped; overflow set and held until reset.
  - Pointers and next_index unchanged.
- Dequeue: when out_valid && out_ready, rd_ptr += 1. out_valid = (count != 0).
- out_* presents the head entry combinationally from storage: zero-latency first-word fall-through. Minimum enqueue-to-out_valid latency = 1 cycle.
- count_next = count + (accepted ? nvalid : 0) - (deq ? 1 : 0).
  - Simultaneous enqueue and dequeue both take effect in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally; count disambiguates full/empty.
- out_ready while empty: no effect.
- out_* stable while out_valid && !out_ready.

Optional Feature:
- Macro DIFF_QUEUE_STAT_EN.
- Defined: adds outputs
  - stat_hwm [$clog2(DEPTH+1)]: max count since reset, updated with count_next.
  - stat_commits [64]: total entries dequeued, saturating at all-ones.
  - stat_stall [32]: cycles with out_valid && !out_ready, saturating.
  - All three reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package diff_pkg:
  - diff_commit_t struct {index[8], pc[XLEN], instr[32], skip, wen, wdest[8], wdata[XLEN]}.
  - DIFF_INDEX_W=8, DIFF_INSTR_W=32, DIFF_WDEST_W=8.
- Sub-module diff_lane_compactor: purely combinational.
  - Computes per-lane rank (exclusive prefix popcount of in_valid) and nvalid.
  - Used to generate write addresses and index stamps.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=4'b1111 -> count=0, out_valid=0, in_ready=1, overflow=0, nothing enqueued.
- Compaction: in_valid=4'b1011, pcs 0x80000000/04/08/0C, out_ready=1 -> out stream pc 0x80000000, 0x80000004, 0x8000000C, out_index 0,1,2 on consecutive cycles.
- Fill: DEPTH=16, W=4, out_ready=0, in_valid=4'b1111 every cycle:
  - count 4, 8, 12, 16.
  - in_ready=0 at count 16.
  - 5th group dropped -> overflow=1 and remains 1; count stays 16.
- Steady state: count=8, in_valid=4'b0001 and out_ready=1 each cycle -> count stays 8 for 20 cycles; order preserved; no overflow.
- Wrap: drive 258 single-lane commits with out_ready=1 -> out_index sequence ...,254,255,0,1; pointers wrap without data corruption.
- Mid-operation reset: 10 entries queued, assert reset 1 cycle -> count=0, out_valid=0; next commit dequeues with out_index=0.
